// File: rtl/router_reg_pipe.sv
// Router datapath register stage: header capture, payload forwarding with a one-byte
// full-FIFO hold buffer, XOR/CRC parity and length checking, saturating packet counters.
module router_reg_pipe #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       PAR_MODE = 0,
    parameter logic [DATA_W-1:0] POLY     = DATA_W'(8'h07),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              err_len,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt
);

    localparam int unsigned LEN_W = DATA_W - 2;

    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] hold;
    logic              hold_vld;
    logic              hold_par;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] rx_par;
    logic [LEN_W-1:0]  pay_cnt;
    logic [LEN_W-1:0]  len_exp;
    logic              par_bad;
    logic              len_bad;

    // One parity step: XOR, or an MSB-first CRC shift of byte b into register a.
    function automatic logic [DATA_W-1:0] par_step(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] c;
        c = a ^ b;
        if (PAR_MODE != 0) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                c = c[DATA_W-1] ? ((c << 1) ^ POLY) : (c << 1);
            end
        end
        return c;
    endfunction

    always_comb begin
        par_bad = (acc != rx_par);
        len_bad = (pay_cnt != len_exp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr           <= '0;
            hold          <= '0;
            hold_vld      <= 1'b0;
            hold_par      <= 1'b0;
            acc           <= '0;
            rx_par        <= '0;
            pay_cnt       <= '0;
            len_exp       <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
            err_len       <= 1'b0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
        end else begin
            dout_valid <= 1'b0;
            // detect_add blocks every other strobe, even without pkt_valid
            if (detect_add) begin
                if (pkt_valid) begin
                    hdr         <= din;
                    len_exp     <= din[DATA_W-1:2];
                    acc         <= par_step('0, din);
                    pay_cnt     <= '0;
                    parity_done <= 1'b0;
                    err         <= 1'b0;
                    err_len     <= 1'b0;
                    hold_vld    <= 1'b0;
                end
            end else if (lfd_state) begin
                dout       <= hdr;
                dout_valid <= 1'b1;
            end else if (ld_state) begin
                if (!fifo_full) begin
                    dout       <= din;
                    dout_valid <= 1'b1;
                    if (pkt_valid) begin
                        acc <= par_step(acc, din);
                        if (pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
                    end else begin
                        rx_par        <= din;
                        parity_done   <= 1'b1;
                        low_pkt_valid <= 1'b1;
                    end
                end else begin
                    hold     <= din;
                    hold_vld <= 1'b1;
                    hold_par <= ~pkt_valid;
                    if (!pkt_valid) low_pkt_valid <= 1'b1;
                end
            end else if (laf_state) begin
                if (hold_vld) begin
                    dout       <= hold;
                    dout_valid <= 1'b1;
                    hold_vld   <= 1'b0;
                    if (!hold_par) begin
                        acc <= par_step(acc, hold);
                        if (pay_cnt != '1) pay_cnt <= pay_cnt + 1'b1;
                    end else begin
                        rx_par      <= hold;
                        parity_done <= 1'b1;
                    end
                end
            end else if (rst_int_reg) begin
                low_pkt_valid <= 1'b0;
                if (parity_done) begin
                    err     <= par_bad;
                    err_len <= len_bad;
                    if (par_bad || len_bad) begin
                        if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
                    end else begin
                        if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_router_reg_pipe.sv
// Scoreboard bench for router_reg_pipe: XOR, CRC and 2-bit-counter instances share stimulus.
module tb_router_reg_pipe;

    localparam logic [5:0] ST_IDLE = 6'b000000;
    localparam logic [5:0] ST_DA   = 6'b000001;
    localparam logic [5:0] ST_LFD  = 6'b000010;
    localparam logic [5:0] ST_LD   = 6'b000100;
    localparam logic [5:0] ST_LAF  = 6'b001000;
    localparam logic [5:0] ST_FULL = 6'b010000;
    localparam logic [5:0] ST_RIR  = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid, fifo_full;
    logic [7:0] din;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

    logic [7:0]  dout;
    logic        dout_valid, parity_done, low_pkt_valid, err, err_len;
    logic [15:0] good_cnt, bad_cnt;

    logic [7:0]  crc_dout;
    logic        crc_dout_valid, crc_parity_done, crc_low_pkt_valid, crc_err, crc_err_len;
    logic [15:0] crc_good, crc_bad;

    logic [7:0]  sat_dout;
    logic        sat_dout_valid, sat_parity_done, sat_low_pkt_valid, sat_err, sat_err_len;
    logic [1:0]  sat_good, sat_bad;

    int         n_vec = 0;
    int         n_err = 0;
    int         pulses = 0;
    int         exp_good = 0;
    int         exp_bad = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    router_reg_pipe dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .dout(dout), .dout_valid(dout_valid), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err), .err_len(err_len),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    router_reg_pipe #(.PAR_MODE(1), .POLY(8'h07)) dut_crc (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .dout(crc_dout), .dout_valid(crc_dout_valid), .parity_done(crc_parity_done),
        .low_pkt_valid(crc_low_pkt_valid), .err(crc_err), .err_len(crc_err_len),
        .good_cnt(crc_good), .bad_cnt(crc_bad)
    );

    router_reg_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .dout(sat_dout), .dout_valid(sat_dout_valid), .parity_done(sat_parity_done),
        .low_pkt_valid(sat_low_pkt_valid), .err(sat_err), .err_len(sat_err_len),
        .good_cnt(sat_good), .bad_cnt(sat_bad)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every dout_valid pulse pops the next expected byte
    always @(negedge clk) begin
        if (dout_valid) begin
            pulses++;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dout_unexpected: got %0h, expected no load", dout);
            end else begin
                chk("dout", 32'(dout), 32'(q.pop_front()));
            end
        end
    end

    task automatic cyc(input logic [5:0] st, input logic pv, input logic ff, input logic [7:0] d);
        detect_add  = st[0];
        lfd_state   = st[1];
        ld_state    = st[2];
        laf_state   = st[3];
        full_state  = st[4];
        rst_int_reg = st[5];
        pkt_valid   = pv;
        fifo_full   = ff;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_parity_done", 32'(parity_done), 0);
        chk("rst_low_pkt_valid", 32'(low_pkt_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_len", 32'(err_len), 0);
        chk("rst_good_cnt", 32'(good_cnt), 0);
        chk("rst_bad_cnt", 32'(bad_cnt), 0);
        chk("rst_sat_bad", 32'(sat_bad), 0);
    endtask

    // full_at: byte index that meets a full FIFO (n = parity byte), -1 for never
    task automatic send_pkt(input logic [7:0] h, input int n, input logic [7:0] p0,
                            input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] par,
                            input int full_at, input logic e_err, input logic e_len);
        logic [7:0] b;
        logic       pv;
        pulses = 0;
        cyc(ST_DA, 1'b1, 1'b0, h);
        q.push_back(h);
        cyc(ST_LFD, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i <= n; i++) begin
            pv = (i < n);
            if (i == 0)      b = p0;
            else if (i == 1) b = p1;
            else if (i == 2) b = p2;
            else             b = par;
            if (i == n) b = par;
            if (i == full_at) begin
                cyc(ST_LD, pv, 1'b1, b);
                chk("full_no_load", 32'(dout_valid), 0);
                chk("full_parity_done", 32'(parity_done), 0);
                cyc(ST_FULL, pv, 1'b1, 8'h00);
                q.push_back(b);
                cyc(ST_LAF, pv, 1'b0, 8'h00);
                chk("laf_parity_done", 32'(parity_done), 32'(!pv));
            end else begin
                q.push_back(b);
                cyc(ST_LD, pv, 1'b0, b);
            end
        end
        chk("low_pkt_valid_set", 32'(low_pkt_valid), 1);
        cyc(ST_RIR, 1'b0, 1'b0, 8'h00);
        if (e_err || e_len) exp_bad++;
        else exp_good++;
        chk("err", 32'(err), 32'(e_err));
        chk("err_len", 32'(err_len), 32'(e_len));
        chk("low_pkt_valid_clr", 32'(low_pkt_valid), 0);
        chk("good_cnt", 32'(good_cnt), 32'(exp_good));
        chk("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
        chk("pulse_count", 32'(pulses), 32'(n + 2));
        cyc(ST_IDLE, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
        full_state = 1'b0; rst_int_reg = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
        din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        reset = 1'b0;
        cyc(ST_IDLE, 1'b0, 1'b0, 8'h00);

        // T1..T4b on the XOR instance: 0C^11^22^33 = 0C
        send_pkt(8'h0C, 3, 8'h11, 8'h22, 8'h33, 8'h0C, -1, 1'b0, 1'b0);
        send_pkt(8'h0C, 3, 8'h11, 8'h22, 8'h33, 8'h0D, -1, 1'b1, 1'b0);
        send_pkt(8'h0C, 2, 8'h11, 8'h22, 8'h00, 8'h3F, -1, 1'b0, 1'b1);
        send_pkt(8'h0C, 3, 8'h11, 8'h22, 8'h33, 8'h0C, 1, 1'b0, 1'b0);
        send_pkt(8'h0C, 3, 8'h11, 8'h22, 8'h33, 8'h0C, 3, 1'b0, 1'b0);

        // T5: CRC-8/0x07 of 04,1C is 00; XOR instance sees 04^1C = 18
        send_pkt(8'h04, 1, 8'h1C, 8'h00, 8'h00, 8'h00, -1, 1'b1, 1'b0);
        chk("crc_err_ok", 32'(crc_err), 0);
        chk("crc_err_len_ok", 32'(crc_err_len), 0);
        send_pkt(8'h04, 1, 8'h1C, 8'h00, 8'h00, 8'h07, -1, 1'b1, 1'b0);
        chk("crc_err_bad", 32'(crc_err), 1);
        chk("crc_err_len_bad", 32'(crc_err_len), 0);

        // T6: asynchronous reset between clock edges, mid-payload
        q.push_back(8'h0C);
        cyc(ST_DA, 1'b1, 1'b0, 8'h0C);
        cyc(ST_LFD, 1'b1, 1'b0, 8'h00);
        cyc(ST_LD, 1'b1, 1'b0, 8'h11);
        #2;
        reset = 1'b1;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
        full_state = 1'b0; rst_int_reg = 1'b0; pkt_valid = 1'b0;
        #1;
        chk_reset_state();
        q.delete();
        exp_good = 0;
        exp_bad  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(ST_IDLE, 1'b0, 1'b0, 8'h00);

        send_pkt(8'h0C, 3, 8'h11, 8'h22, 8'h33, 8'h0C, -1, 1'b0, 1'b0);
        chk("sat_good", 32'(sat_good), 1);
        for (int k = 1; k <= 4; k++) begin
            send_pkt(8'h0C, 3, 8'h11, 8'h22, 8'h33, 8'h0D, -1, 1'b1, 1'b0);
            chk("sat_bad", 32'(sat_bad), (k > 3) ? 32'd3 : 32'(k));
        end

        chk("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
